// File: rtl/fp16_pkg.sv
// Shared fp16 format constants and the converter state encoding.
package fp16_pkg;

    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    localparam int FP16_EXP_MAX = 31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } conv_state_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational fp16 field decode and class detection, shared with the fp16 adder.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]            a,
    output logic                   sign,
    output logic [FP16_EXP_W-1:0]  exp,
    output logic [FP16_FRAC_W:0]   mant11,
    output logic                   is_zero,
    output logic                   is_sub,
    output logic                   is_inf,
    output logic                   is_nan
);

    localparam logic [FP16_EXP_W-1:0] EXP_ALL_ONES = FP16_EXP_W'(FP16_EXP_MAX);

    logic [FP16_FRAC_W-1:0] frac;
    logic                   exp_zero;
    logic                   exp_ones;
    logic                   frac_zero;

    assign sign      = a[15];
    assign exp       = a[14:10];
    assign frac      = a[9:0];
    assign exp_zero  = (exp == '0);
    assign exp_ones  = (exp == EXP_ALL_ONES);
    assign frac_zero = (frac == '0);

    // Hidden bit is set for every non-zero exponent, including Inf/NaN.
    assign mant11  = {~exp_zero, frac};
    assign is_zero = exp_zero & frac_zero;
    assign is_sub  = exp_zero & ~frac_zero;
    assign is_inf  = exp_ones & frac_zero;
    assign is_nan  = exp_ones & ~frac_zero;

endmodule

// File: rtl/fp16_to_int16_seq.sv
// Multicycle fp16 -> int16 converter: operand decoded on accept, then aligned
// by a one-bit-per-cycle shifter before rounding and sign application.
module fp16_to_int16_seq
    import fp16_pkg::*;
#(
    parameter bit ROUND_NEAREST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        overflow,
    output logic        inexact,
    output logic        invalid
);

    localparam logic [FP16_EXP_W-1:0] EXP_BIAS  = FP16_EXP_W'(FP16_BIAS);
    localparam logic [FP16_EXP_W-1:0] EXP_HALF  = FP16_EXP_W'(FP16_BIAS - 1);
    localparam logic [FP16_EXP_W-1:0] EXP_ALIGN = FP16_EXP_W'(FP16_BIAS + FP16_FRAC_W);
    localparam logic [FP16_EXP_W-1:0] EXP_SAT   = FP16_EXP_W'(FP16_BIAS + 15);
    localparam logic [15:0]           SAT_POS   = 16'h7FFF;
    localparam logic [15:0]           SAT_NEG   = 16'h8000;

    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W:0]   mant11;
    logic                   is_zero;
    logic                   is_sub;
    logic                   is_inf;
    logic                   is_nan;

    fp16_classify u_classify (
        .a       (a),
        .sign    (sign),
        .exp     (exp),
        .mant11  (mant11),
        .is_zero (is_zero),
        .is_sub  (is_sub),
        .is_inf  (is_inf),
        .is_nan  (is_nan)
    );

    conv_state_t state;
    conv_state_t state_next;

    logic [15:0] acc;
    logic [3:0]  cnt;
    logic        shift_left;
    logic        guard;
    logic        sticky;
    logic        sgn;
    logic        rnd_en;
    logic        ovf_r;
    logic        inx_r;
    logic        inv_r;

    logic [15:0] init_acc;
    logic [3:0]  init_cnt;
    logic        init_left;
    logic        init_rnd;
    logic        init_ovf;
    logic        init_inx;
    logic        init_inv;

    logic        round_up;
    logic [15:0] acc_rnd;
    logic [15:0] fin_result;

    // Decode of the operand presented with start: magnitude seed, shift plan, flags.
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        init_acc  = {5'b0, mant11};
        init_cnt  = '0;
        init_left = 1'b0;
        init_rnd  = 1'b0;
        init_ovf  = 1'b0;
        init_inx  = 1'b0;
        init_inv  = 1'b0;
        if (is_nan) begin
            init_acc = '0;
            init_inv = 1'b1;
        end else if (is_inf) begin
            init_acc = sign ? SAT_NEG : SAT_POS;
            init_ovf = 1'b1;
        end else if (exp >= EXP_SAT) begin
            // -32768 is the only representable value at this magnitude.
            init_acc = sign ? SAT_NEG : SAT_POS;
            init_ovf = ~(sign && (exp == EXP_SAT) && (mant11[FP16_FRAC_W-1:0] == '0));
        end else if (is_zero) begin
            init_acc = '0;
        end else if (is_sub || (exp < EXP_BIAS)) begin
            init_acc = '0;
            init_inx = 1'b1;
            if (ROUND_NEAREST && (exp == EXP_HALF) && (mant11[FP16_FRAC_W-1:0] != '0)) begin
                init_acc = 16'd1;
            end
        end else if (exp >= EXP_ALIGN) begin
            init_cnt  = 4'(exp - EXP_ALIGN);
            init_left = 1'b1;
        end else begin
            init_cnt = 4'(EXP_ALIGN - exp);
            init_rnd = ROUND_NEAREST;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (init_cnt != '0) ? S_SHIFT : S_FINISH;
                end
            end
            S_SHIFT: begin
                if (cnt == 4'd1) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Magnitude stays below 2048 on the rounding path, so the increment cannot carry out.
    assign round_up   = rnd_en & guard & (sticky | acc[0]);
    assign acc_rnd    = acc + {15'b0, round_up};
    assign fin_result = sgn ? (~acc_rnd + 16'd1) : acc_rnd;
    assign busy       = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            guard      <= 1'b0;
            sticky     <= 1'b0;
            sgn        <= 1'b0;
            rnd_en     <= 1'b0;
            ovf_r      <= 1'b0;
            inx_r      <= 1'b0;
            inv_r      <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            inexact    <= 1'b0;
            invalid    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc        <= init_acc;
                        cnt        <= init_cnt;
                        shift_left <= init_left;
                        guard      <= 1'b0;
                        sticky     <= 1'b0;
                        sgn        <= sign;
                        rnd_en     <= init_rnd;
                        ovf_r      <= init_ovf;
                        inx_r      <= init_inx;
                        inv_r      <= init_inv;
                        overflow   <= 1'b0;
                        inexact    <= 1'b0;
                        invalid    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (shift_left) begin
                        acc <= {acc[14:0], 1'b0};
                    end else begin
                        acc    <= {1'b0, acc[15:1]};
                        guard  <= acc[0];
                        sticky <= sticky | guard;
                    end
                    cnt <= cnt - 4'd1;
                end
                S_FINISH: begin
                    result   <= fin_result;
                    overflow <= ovf_r;
                    inexact  <= inx_r | guard | sticky;
                    invalid  <= inv_r;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
